dir_input_conditioner: RTL and testbench
========================================

Name: dir_input_conditioner

Overview:
- Upstream stage of the game FSM. Turns the four raw Nexys4 push-buttons (U/D/L/R) into a clean, latched, one-hot movement request.
- Per button: 2-FF synchronizer, counter-based debounce, rising-edge detect.
- Requested direction persists after release (Pac-Man style) until a new press or a clear from the FSM.
- Runs on the 100 MHz system clock.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronized level must differ from the debounced state before it is accepted (10 ms at 100 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 20, width of each debounce counter.

Ports:
- clk  in  1  100 MHz system clock.
- cpu_resetn  in  1  asynchronous active-low reset.
- btnU_in  in  1  raw up button, asynchronous, active-high.
- btnD_in  in  1  raw down button.
- btnL_in  in  1  raw left button.
- btnR_in  in  1  raw right button.
- dir_clear  in  1  synchronous one-cycle pulse from game FSM (death/level restart); drops the latched direction.
- move_up  out  1  latched direction is up.
- move_down  out  1  latched direction is down.
- move_left  out  1  latched direction is left.
- move_right  out  1  latched direction is right.
- dir_code  out  2  encoded direction: 0 up, 1 down, 2 left, 3 right; valid only when dir_valid=1.
- dir_valid  out  1  a direction is latched.
- press_pulse  out  1  one-cycle strobe when the latched direction is (re)loaded by a press.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (cpu_resetn). While cpu_resetn=0, all state is 0: synchronizers, debounced levels, counters, edge regs, move_*, dir_code, dir_valid, press_pulse.
- Synchronizer: two flops per button, sync1 then sync2. No logic between the two flops.
- Debounce, per button, with state db and counter cnt:
  - If sync2==db: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: db<=sync2, cnt<=0.
  - Else: cnt<=cnt+1.
  - Any bounce back to the db level before acceptance restarts the count from 0.
- Edge detect: db_d<=db; rise=db & ~db_d. Releases produce no event.
- Latency: pin first sampled high at edge 1 gives db=1 after edge DEBOUNCE_CYCLES+2. move_* and press_pulse update after edge DEBOUNCE_CYCLES+3.
- Direction register, updated each edge:
  - dir_clear=1: dir_valid<=0, move_*<=0, press_pulse<=0. Clear wins over a simultaneous rise, and that rise is discarded.
  - Else, any rise: load the highest-priority rising button, priority U > D > L > R. Set dir_valid<=1, the matching move_* to 1 and all others to 0, dir_code to match, press_pulse<=1.
  - Else: hold all, press_pulse<=0.
- A rise on the already-latched direction still pulses press_pulse. The FSM uses this as a re-press.
- A rise on any button while another is still held overrides the current direction (last press wins).
- move_* is always one-hot or all-zero. dir_code is held at its last value when dir_valid=0, and is 0 after reset.
- Reset mid-debounce: all progress is lost. If a button is held through reset deassertion, it is treated as a fresh press after DEBOUNCE_CYCLES+3 cycles.
- All outputs are registered; there is no combinational path from any input to any output.

Test Plan (DEBOUNCE_CYCLES=8, CNT_W=4):
- Reset, then btnU_in held high from edge 1 → move_up=1, dir_valid=1, dir_code=0 and press_pulse=1 for exactly one cycle, all after edge 11. Release → move_up stays 1.
- btnL_in toggles high 5 cycles, low 1, high 5 (bounce) → no change. Then held high 8+ cycles → move_left=1, dir_code=2, 11 cycles after the last low-to-high sample.
- btnD_in and btnR_in asserted on the same edge → move_down=1, dir_code=1, move_right=0. One press_pulse.
- Right latched; btnU_in pressed while btnR_in held → move_up=1 and move_right=0 after 11 cycles.
- dir_clear asserted on the same edge as a debounced rise of btnL_in → dir_valid=0, all move_*=0, press_pulse=0. dir_code keeps its prior value.
- btnR_in held; cpu_resetn pulsed low mid-debounce (cnt=5) → outputs 0 immediately. After release, move_right=1 exactly 11 cycles after the first post-reset edge.

Source files
------------

// File: rtl/dir_input_conditioner.sv
// rtl/dir_input_conditioner.sv - button synchronizer, debouncer and latched direction request
// Raw U/D/L/R buttons become a persistent one-hot move request for the game FSM.
module dir_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       cpu_resetn,
  input  logic       btnU_in,
  input  logic       btnD_in,
  input  logic       btnL_in,
  input  logic       btnR_in,
  input  logic       dir_clear,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic [1:0] dir_code,
  output logic       dir_valid,
  output logic       press_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit order everywhere: 0 = up, 1 = down, 2 = left, 3 = right.
  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] db;
  logic [3:0] db_d;
  logic [3:0] rise;
  logic [3:0] move_q;

  assign raw = {btnR_in, btnL_in, btnD_in, btnU_in};

  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A level must differ from db for DEBOUNCE_CYCLES consecutive cycles to be taken.
  for (genvar i = 0; i < 4; i++) begin : g_db
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
        cnt   <= '0;
        db[i] <= 1'b0;
      end else if (sync2[i] == db[i]) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db[i] <= sync2[i];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      db_d <= '0;
    end else begin
      db_d <= db;
    end
  end

  assign rise = db & ~db_d;

  logic       any_rise;
  logic [1:0] sel_code;

  always_comb begin
    any_rise = |rise;
    sel_code = 2'd0;
    if (rise[0]) begin
      sel_code = 2'd0;
    end else if (rise[1]) begin
      sel_code = 2'd1;
    end else if (rise[2]) begin
      sel_code = 2'd2;
    end else if (rise[3]) begin
      sel_code = 2'd3;
    end
  end

  // Clear beats a coincident rise; dir_code keeps its last value when cleared.
  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      move_q      <= '0;
      dir_code    <= 2'd0;
      dir_valid   <= 1'b0;
      press_pulse <= 1'b0;
    end else if (dir_clear) begin
      move_q      <= '0;
      dir_valid   <= 1'b0;
      press_pulse <= 1'b0;
    end else if (any_rise) begin
      move_q      <= 4'b0001 << sel_code;
      dir_code    <= sel_code;
      dir_valid   <= 1'b1;
      press_pulse <= 1'b1;
    end else begin
      press_pulse <= 1'b0;
    end
  end

  assign move_up    = move_q[0];
  assign move_down  = move_q[1];
  assign move_left  = move_q[2];
  assign move_right = move_q[3];

endmodule

// File: tb/tb_dir_input_conditioner.sv
// tb/tb_dir_input_conditioner.sv - directed vector bench for dir_input_conditioner
module tb_dir_input_conditioner;

  logic       clk;
  logic       cpu_resetn;
  logic       btnU_in, btnD_in, btnL_in, btnR_in;
  logic       dir_clear;
  logic       move_up, move_down, move_left, move_right;
  logic [1:0] dir_code;
  logic       dir_valid;
  logic       press_pulse;

  int checks = 0;
  int fails  = 0;

  dir_input_conditioner #(.DEBOUNCE_CYCLES(8), .CNT_W(4)) dut (
    .clk        (clk),
    .cpu_resetn (cpu_resetn),
    .btnU_in    (btnU_in),
    .btnD_in    (btnD_in),
    .btnL_in    (btnL_in),
    .btnR_in    (btnR_in),
    .dir_clear  (dir_clear),
    .move_up    (move_up),
    .move_down  (move_down),
    .move_left  (move_left),
    .move_right (move_right),
    .dir_code   (dir_code),
    .dir_valid  (dir_valid),
    .press_pulse(press_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // btn bits: 0 = U, 1 = D, 2 = L, 3 = R; move uses the same order.
  typedef struct {
    logic [3:0] btn;
    logic       clr;
    int         cycles;
    logic [3:0] move;
    logic [1:0] code;
    logic       valid;
    logic       pulse;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] btn, input logic clr, input int cycles,
                     input logic [3:0] move, input logic [1:0] code,
                     input logic valid, input logic pulse);
    vec_t v;
    v.btn = btn; v.clr = clr; v.cycles = cycles;
    v.move = move; v.code = code; v.valid = valid; v.pulse = pulse;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] btn, input logic clr);
    btnU_in = btn[0];
    btnD_in = btn[1];
    btnL_in = btn[2];
    btnR_in = btn[3];
    dir_clear = clr;
  endtask

  task automatic check(input string name, input logic [3:0] move, input logic [1:0] code,
                       input logic valid, input logic pulse);
    logic [7:0] act, exp;
    act = {move_right, move_left, move_down, move_up, dir_code, dir_valid, press_pulse};
    exp = {move, code, valid, pulse};
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got move=%b code=%0d valid=%b pulse=%b, expected move=%b code=%0d valid=%b pulse=%b",
               name, act[7:4], act[3:2], act[1], act[0], move, code, valid, pulse);
    end
  endtask

  initial begin
    cpu_resetn = 1'b0;
    drive(4'b0000, 1'b0);

    // U press / latch / release
    add(4'b0001, 0, 10, 4'b0000, 2'd0, 0, 0);
    add(4'b0001, 0,  1, 4'b0001, 2'd0, 1, 1);
    add(4'b0001, 0,  1, 4'b0001, 2'd0, 1, 0);
    add(4'b0000, 0, 20, 4'b0001, 2'd0, 1, 0);
    // L bounce, then a clean hold
    add(4'b0100, 0,  5, 4'b0001, 2'd0, 1, 0);
    add(4'b0000, 0,  1, 4'b0001, 2'd0, 1, 0);
    add(4'b0100, 0, 10, 4'b0001, 2'd0, 1, 0);
    add(4'b0100, 0,  1, 4'b0100, 2'd2, 1, 1);
    add(4'b0000, 0, 20, 4'b0100, 2'd2, 1, 0);
    // D and R together: D has priority
    add(4'b1010, 0, 10, 4'b0100, 2'd2, 1, 0);
    add(4'b1010, 0,  1, 4'b0010, 2'd1, 1, 1);
    add(4'b1010, 0,  1, 4'b0010, 2'd1, 1, 0);
    add(4'b0000, 0, 20, 4'b0010, 2'd1, 1, 0);
    // R latched, then U pressed while R held
    add(4'b1000, 0, 11, 4'b1000, 2'd3, 1, 1);
    add(4'b1001, 0, 10, 4'b1000, 2'd3, 1, 0);
    add(4'b1001, 0,  1, 4'b0001, 2'd0, 1, 1);
    add(4'b0000, 0, 20, 4'b0001, 2'd0, 1, 0);
    // R latched, then re-pressed
    add(4'b1000, 0, 11, 4'b1000, 2'd3, 1, 1);
    add(4'b0000, 0, 20, 4'b1000, 2'd3, 1, 0);
    add(4'b1000, 0, 11, 4'b1000, 2'd3, 1, 1);
    add(4'b0000, 0, 20, 4'b1000, 2'd3, 1, 0);
    // clear coincident with the debounced L rise
    add(4'b0100, 0, 10, 4'b1000, 2'd3, 1, 0);
    add(4'b0100, 1,  1, 4'b0000, 2'd3, 0, 0);
    add(4'b0100, 0,  5, 4'b0000, 2'd3, 0, 0);
    add(4'b0000, 0, 20, 4'b0000, 2'd3, 0, 0);
    // relatch R ahead of the reset-mid-debounce case
    add(4'b1000, 0, 11, 4'b1000, 2'd3, 1, 1);
    add(4'b0000, 0, 20, 4'b1000, 2'd3, 1, 0);

    repeat (3) tick();
    check("in_reset", 4'b0000, 2'd0, 0, 0);
    cpu_resetn = 1'b1;
    tick();
    check("after_reset", 4'b0000, 2'd0, 0, 0);
    // realign: the first table step's first edge is the next one
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].btn, vecs[i].clr);
      repeat (vecs[i].cycles) tick();
      check($sformatf("vec%0d", i), vecs[i].move, vecs[i].code, vecs[i].valid, vecs[i].pulse);
    end
    drive(4'b0000, 1'b0);

    // R held; reset asserted once the counter has reached 5
    drive(4'b1000, 1'b0);
    repeat (7) tick();
    cpu_resetn = 1'b0;
    #1;
    check("reset_async", 4'b0000, 2'd0, 0, 0);
    repeat (2) tick();
    check("reset_held", 4'b0000, 2'd0, 0, 0);
    cpu_resetn = 1'b1;
    repeat (10) tick();
    check("post_reset_10", 4'b0000, 2'd0, 0, 0);
    tick();
    check("post_reset_11", 4'b1000, 2'd3, 1, 1);
    tick();
    check("post_reset_12", 4'b1000, 2'd3, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
